// File: rtl/div_unit_pkg.sv
// ----------------------------------------------------------------------------
// div_unit_pkg
//   Shared definitions for the RV32M divider: operation encodings, FSM state
//   encodings and small decode helpers used by div_unit.
// ----------------------------------------------------------------------------
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input div_op_e op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
//   One combinational radix-2 restoring division iteration.
//   rem_i     : partial remainder (W+1 bits)
//   dvd_bit_i : next dividend bit shifted into the remainder
//   dvs_i     : divisor magnitude
//   rem_o     : partial remainder after the trial subtract / restore
//   q_bit_o   : quotient bit produced by this iteration
// ----------------------------------------------------------------------------
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic         dvd_bit_i,
    input  logic [W-1:0] dvs_i,
    output logic [W:0]   rem_o,
    output logic         q_bit_o
);

    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    always_comb begin
        shifted = {rem_i, dvd_bit_i};
        // Extra top bit acts as the borrow / sign of the trial subtraction.
        diff    = shifted - {2'b00, dvs_i};
        q_bit_o = ~diff[W+1];
        rem_o   = q_bit_o ? diff[W:0] : shifted[W:0];
    end

endmodule

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   One quotient bit per cycle; DATA_WIDTH iterations per operation.
//
//   clk_i, rst_i    : clock, synchronous active-high reset
//   start_i         : launch request, accepted in IDLE or DONE
//   flush_i         : abort; wins over start_i, result register untouched
//   a_i, b_i, op_i  : dividend, divisor, operation (sampled at accept only)
//   busy_o          : iteration in progress
//   valid_o         : one-cycle pulse, res_o holds a new result
//   res_o           : registered quotient or remainder
//
//   Build option: DIV_FAST_PATH_EN -- divide-by-zero, signed overflow and
//   divisor == 1 complete straight from accept (valid_o the next cycle).
// ----------------------------------------------------------------------------
import div_unit_pkg::*;

module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [1:0]            op_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    div_state_e   state_q, state_d;
    div_op_e      op_q, op_d;
    logic [W:0]   rem_q, rem_d;
    logic [W-1:0] dvd_q, dvd_d;    // dividend shifts out MSB-first, quotient shifts in
    logic [W-1:0] dvs_q, dvs_d;
    logic [W-1:0] a_q, a_d;        // raw dividend, needed for the divide-by-zero remainder
    logic [W-1:0] res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         qneg_q, qneg_d;
    logic         rneg_q, rneg_d;
    logic         dbz_q, dbz_d;
    logic         ovf_q, ovf_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;

    logic [W:0]   step_rem;
    logic         step_bit;

    logic         in_signed, in_dbz, in_ovf;
    div_op_e      in_op;

    div_step #(.W(W)) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[W-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_bit)
    );

    // Final selection with special-case overrides. The divide-by-zero
    // remainder is the raw dividend, so no sign correction is applied there.
    function automatic logic [W-1:0] final_res(
        input div_op_e      op,
        input logic [W-1:0] quo,
        input logic [W-1:0] rem,
        input logic [W-1:0] a_raw,
        input logic         qneg,
        input logic         rneg,
        input logic         dbz,
        input logic         ovf
    );
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (dbz) begin
            q = '1;
            r = a_raw;
        end else if (ovf) begin
            q = MIN_NEG;
            r = '0;
        end else begin
            q = qneg ? -quo : quo;
            r = rneg ? -rem : rem;
        end
        return op_is_rem(op) ? r : q;
    endfunction

    always_comb begin
        in_op     = div_op_e'(op_i);
        in_signed = op_is_signed(in_op);
        in_dbz    = (b_i == '0);
        in_ovf    = in_signed && (a_i == MIN_NEG) && (b_i == '1);

        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        if (flush_i) begin
            state_d = DIV_IDLE;
        end else if (start_i && (state_q != DIV_CALC)) begin
            op_d   = in_op;
            rem_d  = '0;
            // |0x80..0| wraps to 0x80..0, which is the right unsigned magnitude.
            dvd_d  = (in_signed && a_i[W-1]) ? -a_i : a_i;
            dvs_d  = (in_signed && b_i[W-1]) ? -b_i : b_i;
            a_d    = a_i;
            qneg_d = in_signed && (a_i[W-1] ^ b_i[W-1]);
            rneg_d = in_signed && a_i[W-1];
            dbz_d  = in_dbz;
            ovf_d  = in_ovf;
            cnt_d  = CW'(W - 1);
            state_d = DIV_CALC;
`ifdef DIV_FAST_PATH_EN
            if (in_dbz || in_ovf || (b_i == {{(W-1){1'b0}}, 1'b1})) begin
                // With b == 1 the quotient is the raw dividend and remainder 0.
                res_d   = final_res(in_op, a_i, '0, a_i, 1'b0, 1'b0, in_dbz, in_ovf);
                cnt_d   = '0;
                state_d = DIV_DONE;
            end
`endif
        end else begin
            case (state_q)
                DIV_CALC: begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[W-2:0], step_bit};
                    if (cnt_q == '0) begin
                        res_d   = final_res(op_q, {dvd_q[W-2:0], step_bit}, step_rem[W-1:0],
                                            a_q, qneg_q, rneg_q, dbz_q, ovf_q);
                        state_d = DIV_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end

        busy_d  = (state_d == DIV_CALC);
        valid_d = (state_d == DIV_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DIV_IDLE;
            op_q    <= DIV_OP_DIV;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign res_o   = res_q;

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit. A reference model tracks, per clock
//   edge, when the pending result is due and what it must be (computed with
//   plain integer division), and a compare thread checks busy/valid/res every
//   cycle. Directed operations additionally pin literal results and latency.
// ----------------------------------------------------------------------------
module tb_div_unit;

    localparam int DW = 32;
`ifdef DIV_FAST_PATH_EN
    localparam int FL = 1;
`else
    localparam int FL = 33;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic [1:0]    op = 2'b00;
    logic          busy_o, valid_o;
    logic [DW-1:0] res_o;

    int total = 0;
    int bad   = 0;

    // Model state
    int            edge_n = 0;
    bit            m_pend = 0;
    int            m_due  = 0;
    logic [DW-1:0] m_nres = '0;
    logic [DW-1:0] m_res  = '0;
    bit            exp_busy, exp_valid;

    div_unit #(.DATA_WIDTH(DW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .flush_i (flush),
        .a_i     (a),
        .b_i     (b),
        .op_i    (op),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .res_o   (res_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_res(input logic [1:0] o, input logic [DW-1:0] x,
                                              input logic [DW-1:0] y);
        bit sgn;
        bit is_rem;
        sgn    = (o == 2'b00) || (o == 2'b10);
        is_rem = (o == 2'b10) || (o == 2'b11);
        if (y == 0) return is_rem ? x : 32'hFFFF_FFFF;
        if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return is_rem ? 32'h0 : 32'h8000_0000;
        if (sgn) begin
            if (is_rem) return $signed(x) % $signed(y);
            return $signed(x) / $signed(y);
        end
        return is_rem ? x % y : x / y;
    endfunction

    // Edges from accept to the edge that opens the valid cycle.
    function automatic int ref_lat(input logic [1:0] o, input logic [DW-1:0] x,
                                   input logic [DW-1:0] y);
`ifdef DIV_FAST_PATH_EN
        bit sgn;
        sgn = (o == 2'b00) || (o == 2'b10);
        if (y == 0 || y == 1 || (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 0;
`else
        if (o == 2'b11 && x == 0 && y == 0) return 32;
`endif
        return 32;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic rand_operands();
        op = 2'($urandom);
        a  = $urandom;
        b  = $urandom;
    endtask

    // Issue one operation from the current negedge; check latency and result.
    task automatic do_op(input logic [1:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input logic [DW-1:0] exp, input int exp_lat, input string nm);
        int n;
        n = 0;
        while (busy_o && n < 40) begin @(negedge clk); n++; end
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        rand_operands();
        n = 1;
        while (!valid_o && n < 40) begin @(negedge clk); n++; end
        check({nm, " latency"}, 64'(n), 64'(exp_lat));
        check({nm, " result"}, 64'(res_o), 64'(exp));
    endtask

    initial begin
        int n;
        int seen;

        fork
            forever begin
                @(posedge clk);
                edge_n++;
                if (rst) begin
                    m_pend = 0;
                    m_res  = '0;
                end else if (flush) begin
                    m_pend = 0;
                end else if (start && !(m_pend && (edge_n - 1) < m_due)) begin
                    m_pend = 1;
                    m_due  = edge_n + ref_lat(op, a, b);
                    m_nres = ref_res(op, a, b);
                end
                if (m_pend && edge_n == m_due) m_res = m_nres;
                exp_busy  = m_pend && edge_n < m_due;
                exp_valid = m_pend && edge_n == m_due;
                #1;
                check("cycle busy/valid/res", {30'b0, busy_o, valid_o, res_o},
                      {30'b0, exp_busy, exp_valid, m_res});
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset outputs", {30'b0, busy_o, valid_o, res_o}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        do_op(2'b01, 100, 7, 14, 33, "DIVU 100/7");
        do_op(2'b11, 100, 7, 2, 33, "REMU 100/7");
        do_op(2'b00, -32'sd7, 2, 32'hFFFF_FFFD, 33, "DIV -7/2");
        do_op(2'b10, -32'sd7, 2, 32'hFFFF_FFFF, 33, "REM -7/2");
        do_op(2'b00, 7, -32'sd2, 32'hFFFF_FFFD, 33, "DIV 7/-2");
        do_op(2'b10, 7, -32'sd2, 1, 33, "REM 7/-2");
        do_op(2'b01, 5, 0, 32'hFFFF_FFFF, FL, "DIVU 5/0");
        do_op(2'b11, 5, 0, 5, FL, "REMU 5/0");
        do_op(2'b00, -32'sd7, 0, 32'hFFFF_FFFF, FL, "DIV -7/0");
        do_op(2'b10, -32'sd7, 0, 32'hFFFF_FFF9, FL, "REM -7/0");
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FL, "DIV ovf");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, FL, "REM ovf");
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 33, "DIVU ovf operands");
        do_op(2'b00, 32'h8000_0000, 1, 32'h8000_0000, FL, "DIV min/1");
        // Back-to-back: second launch in the DONE cycle of the first.
        do_op(2'b01, 1000, 10, 100, 33, "DIVU 1000/10");
        do_op(2'b01, 32'hFFFF_FFFF, 16, 32'h0FFF_FFFF, 33, "DIVU b2b");

        // Flush at T+10: busy drops at T+11 and no result ever appears.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 1000; b = 3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("busy after flush", 64'(busy_o), 64'h0);
        seen = 0;
        repeat (40) begin @(negedge clk); if (valid_o) seen++; end
        check("no valid after flush", 64'(seen), 64'h0);
        do_op(2'b01, 9, 3, 3, 33, "DIVU 9/3 after flush");

        // start held through CALC: only the first launch counts.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 100; b = 7;
        n = 0;
        while (!valid_o && n < 40) begin
            @(negedge clk);
            n++;
            if (n < 20) begin a = $urandom; b = $urandom; end
            else start = 1'b0;
        end
        start = 1'b0;
        check("held start latency", 64'(n), 64'd33);
        check("held start result", 64'(res_o), 64'd14);

        // start + flush together in IDLE launches nothing.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 50; b = 5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start+flush busy", 64'(busy_o), 64'h0);

        // Reset mid-CALC clears everything on the following cycle.
        do_op(2'b01, 77, 7, 11, 33, "DIVU 77/7");
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 123456; b = 7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset mid-CALC", {30'b0, busy_o, valid_o, res_o}, 64'h0);

        // Random traffic; the per-cycle compare thread does the checking.
        repeat (6000) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 59) == 0);
            rst   = ($urandom_range(0, 699) == 0);
            op    = 2'($urandom);
            case ($urandom_range(0, 7))
                0: b = 0;
                1: b = 1;
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom_range(0, 15);
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = $urandom_range(0, 100);
                default: a = $urandom;
            endcase
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0; rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
